delay_arbiter: RTL and testbench
================================

Name: delay_arbiter

Overview:
- Shares one programmable delay counter among NUM_REQ requesters.
- Each requester asks for a delay of its own length. The block grants the counter to one requester at a time using round-robin.
- It counts the requested delay, then returns a one-cycle done pulse to that requester.
- Sits between timing-event clients (sequencers, pulse generators) and the shared delay-generation resource, so each client does not need its own counter.

Parameters:
- NUM_REQ, 4, number of requesters; must be 2..16.
- CNT_W, 8, width of each requested delay value and of the shared counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_i  input  NUM_REQ  per-requester request level; held high until that requester's done_o pulse.
- dly_i  input  NUM_REQ*CNT_W  per-requester delay value; requester k uses bits [k*CNT_W +: CNT_W]; sampled only at grant.
- gnt_o  output  NUM_REQ  one-hot grant; high from grant through the done cycle inclusive.
- done_o  output  NUM_REQ  one-hot, one-cycle pulse when the granted delay expires.
- busy_o  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst low, asynchronous): all state clears.
  - state = IDLE; gnt_o = 0; done_o = 0; busy_o = 0.
  - Counter = 0; round-robin pointer = 0.
  - Reset mid-count discards the operation; no done pulse is issued.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If any req_i bit is high, pick the first set bit searching upward from the pointer, wrapping past NUM_REQ-1 to 0.
  - At the next edge: gnt_o = onehot(k); counter <= dly_i[k]; pointer <= (k+1) mod NUM_REQ; state -> COUNT.
  - If no request is pending, stay in IDLE.
- COUNT:
  - If req_i[k] is low: abort. Next edge -> IDLE; gnt_o clears; no done pulse; pointer is kept as already advanced.
  - Else if counter == 0: next edge -> DONE.
  - Else: counter <= counter - 1.
- DONE:
  - done_o[k] = 1 and gnt_o[k] stays 1 for exactly one cycle.
  - Next edge -> IDLE; gnt_o and done_o clear.
- Latency:
  - With delay D, gnt_o rises at edge E0 and done_o is high for the cycle after edge E(D+1). Grant-to-done is D+1 cycles.
  - D = 0 gives done one cycle after grant. D = 2^CNT_W - 1 is legal; the counter never wraps.
- Minimum request-to-grant latency is 1 cycle from IDLE.
- Back-to-back:
  - After DONE the block spends one cycle in IDLE before the next grant can be issued. Grant-to-grant period is D+3 cycles.
  - A requester must drop req_i by the edge ending its done cycle. If req_i is still high in IDLE, it is treated as a new request and arbitrated fairly.
- Simultaneous requests: round-robin guarantees each continuously requesting client is granted within NUM_REQ grants.
- Changes to dly_i after grant have no effect on the running count.
- Requests arriving during COUNT/DONE are not latched; they are arbitrated only in IDLE from the live req_i.
- Outputs are registered; no combinational path from req_i to any output.

Optional Feature:
- Macro: DELAY_ARBITER_REMAIN_OUT_EN.
- When defined: adds output port remain_o, width CNT_W.
  - Equals the live counter value during COUNT.
  - 0 in IDLE and DONE; 0 on reset.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Single request: req_i=4'b0001, dly=3 after reset.
  - gnt_o=0001 one edge later.
  - done_o=0001 exactly 4 cycles after gnt_o rose.
  - busy_o low one cycle after done.
- Zero delay: req_i[2]=1, dly=0.
  - done_o=0100 the cycle after gnt_o=0100 rises.
  - gnt_o falls after the done cycle.
- Round-robin fairness: req_i=4'b1111 held continuously, all dly=1.
  - Grant order is 0,1,2,3,0.
  - Each grant is 4 cycles apart (D+3).
- Abort: req_i[1]=1 with dly=10; drop req_i[1] after 3 COUNT cycles.
  - gnt_o clears one edge later; done_o stays 0.
  - Next pending request (req_i[3]) is granted after one IDLE cycle.
- Reset mid-count: assert rst=0 during COUNT with dly=200.
  - All outputs go 0 immediately.
  - After release with req_i=0001, grant goes to requester 0 (pointer reset).
- Max delay with macro DELAY_ARBITER_REMAIN_OUT_EN on: dly=255, CNT_W=8.
  - remain_o counts 255 down to 0.
  - done_o arrives after 256 cycles; no wrap.

Source files
------------

// File: rtl/delay_arbiter.sv
// delay_arbiter: round-robin sharing of one programmable delay counter among NUM_REQ requesters
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   req_i    per-requester request level, held until that requester's done pulse
//   dly_i    per-requester delay, requester k uses [k*CNT_W +: CNT_W], sampled at grant
//   gnt_o    one-hot grant, high from grant through the done cycle
//   done_o   one-hot single-cycle pulse when the granted delay expires
//   busy_o   high whenever the block is not idle
//   remain_o live counter value while counting, else 0
//            (present only when DELAY_ARBITER_REMAIN_OUT_EN is defined)
module delay_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*CNT_W-1:0] dly_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       done_o,
`ifdef DELAY_ARBITER_REMAIN_OUT_EN
    output logic [CNT_W-1:0]         remain_o,
`endif
    output logic                     busy_o
);
    localparam int PW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [PW-1:0] ptr, ptr_nx, idx, idx_nx, pick;
    logic any;
    logic [NUM_REQ-1:0] oh;
    logic [CNT_W-1:0] dly_a [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_dly
        assign dly_a[g] = dly_i[g*CNT_W +: CNT_W];
    end
    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        logic [PW-1:0] j;
        any  = 1'b0;
        pick = '0;
        j    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = PW'((int'(ptr) + i) % NUM_REQ);
            if (req_i[j]) begin
                any  = 1'b1;
                pick = j;
            end
        end
    end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        idx_nx   = idx;
        case (state)
            IDLE: if (any) begin
                state_nx = COUNT;
                cnt_nx   = dly_a[pick];
                ptr_nx   = (pick == PW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                idx_nx   = pick;
            end
            COUNT: if (!req_i[idx]) state_nx = IDLE;
                   else if (cnt == '0) state_nx = DONE;
                   else cnt_nx = cnt - 1'b1;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ptr   <= ptr_nx;
            idx   <= idx_nx;
        end
    end
    // Outputs decode registered state only, so req_i never reaches an output combinationally.
    assign oh     = NUM_REQ'(1) << idx;
    assign gnt_o  = (state != IDLE) ? oh : '0;
    assign done_o = (state == DONE) ? oh : '0;
    assign busy_o = state != IDLE;
`ifdef DELAY_ARBITER_REMAIN_OUT_EN
    // cnt may hold a stale value after an abort, so mask it outside COUNT.
    assign remain_o = (state == COUNT) ? cnt : '0;
`endif
endmodule

// File: tb/tb_delay_arbiter.sv
// tb_delay_arbiter: directed scoreboard bench for delay_arbiter
module tb_delay_arbiter;
    typedef struct {int idx; int d;} exp_t;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] req;
    logic [31:0] dly;
    logic [3:0] gnt, done;
    logic busy;
`ifdef DELAY_ARBITER_REMAIN_OUT_EN
    logic [7:0] remain;
`endif
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int gnt_t = 0;
    int last_t;
    bit seen_gnt, seen_done;
    logic [3:0] prev_gnt = '0;
    int exp_gnt[$];
    exp_t exp_done[$];

    delay_arbiter #(.NUM_REQ(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_i(req), .dly_i(dly),
        .gnt_o(gnt), .done_o(done),
`ifdef DELAY_ARBITER_REMAIN_OUT_EN
        .remain_o(remain),
`endif
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_dly(input int k, input int v);
        dly[k*8 +: 8] = 8'(v);
    endtask

    task automatic push(input int k, input int d, input bit completes);
        exp_t e;
        exp_gnt.push_back(k);
        e.idx = k;
        e.d = d;
        if (completes) exp_done.push_back(e);
    endtask

    // Advance one cycle, sample 1ns after the edge and score grant/done events.
    task automatic tick();
        int k;
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (gnt != 0 && prev_gnt == 0) begin
            seen_gnt = 1;
            gnt_t = cyc;
            if (exp_gnt.size() == 0) check("gnt_unexpected", 32'(gnt), 0);
            else begin
                k = exp_gnt.pop_front();
                check("gnt_idx", 32'(gnt), 32'(1) << k);
            end
        end
        if (done != 0) begin
            seen_done = 1;
            if (exp_done.size() == 0) check("done_unexpected", 32'(done), 0);
            else begin
                e = exp_done.pop_front();
                check("done_idx", 32'(done), 32'(1) << e.idx);
                check("done_latency", 32'(cyc - gnt_t), 32'(e.d + 1));
            end
        end
        prev_gnt = gnt;
    endtask

    task automatic wait_gnt(input int budget);
        int n = 0;
        seen_gnt = 0;
        while (!seen_gnt && n < budget) begin
            tick();
            n++;
        end
        check("gnt_timeout", 32'(seen_gnt), 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        seen_done = 0;
        while (!seen_done && n < budget) begin
            tick();
            n++;
        end
        check("done_timeout", 32'(seen_done), 1);
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        dly = '0;
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
`ifdef DELAY_ARBITER_REMAIN_OUT_EN
        check("rst_remain", 32'(remain), 0);
`endif
        rst = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 0);

        // single request, D=3
        set_dly(0, 3);
        req = 4'b0001;
        push(0, 3, 1);
        tick();
        check("single_gnt", 32'(gnt), 4'b0001);
        check("single_busy", 32'(busy), 1);
        wait_done(10);
        check("single_done", 32'(done), 4'b0001);
        req = '0;
        tick();
        check("single_busy_after", 32'(busy), 0);
        check("single_gnt_after", 32'(gnt), 0);

        // zero delay on requester 2
        set_dly(2, 0);
        req = 4'b0100;
        push(2, 0, 1);
        tick();
        check("zero_gnt", 32'(gnt), 4'b0100);
        check("zero_done_early", 32'(done), 0);
        tick();
        check("zero_done", 32'(done), 4'b0100);
        check("zero_gnt_in_done", 32'(gnt), 4'b0100);
        req = '0;
        tick();
        check("zero_gnt_fall", 32'(gnt), 0);
        check("zero_done_fall", 32'(done), 0);

        // round-robin from a fresh pointer
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) set_dly(k, 1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) push(k % 4, 1, 1);
        for (int n = 0; n < 5; n++) begin
            wait_gnt(10);
            if (n > 0) check("rr_period", 32'(cyc - last_t), 4);
            last_t = cyc;
        end
        wait_done(10);
        req = '0;
        tick();
        check("rr_idle", 32'(busy), 0);

        // abort requester 1 after 3 count cycles; requester 3 waits
        set_dly(1, 10);
        set_dly(3, 2);
        req = 4'b1010;
        push(1, 10, 0);
        push(3, 2, 1);
        tick();
        check("abort_gnt", 32'(gnt), 4'b0010);
        tick();
        tick();
        tick();
        req = 4'b1000;
        tick();
        check("abort_gnt_clear", 32'(gnt), 0);
        check("abort_no_done", 32'(done), 0);
        check("abort_idle", 32'(busy), 0);
        tick();
        check("abort_next_gnt", 32'(gnt), 4'b1000);
        set_dly(3, 50);
        wait_done(10);
        req = '0;
        tick();

        // reset during a long count, then check pointer returned to 0
        set_dly(2, 200);
        req = 4'b0100;
        push(2, 200, 0);
        tick();
        for (int n = 0; n < 5; n++) tick();
        check("midcnt_busy", 32'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_gnt", 32'(gnt), 0);
        check("async_done", 32'(done), 0);
        check("async_busy", 32'(busy), 0);
`ifdef DELAY_ARBITER_REMAIN_OUT_EN
        check("async_remain", 32'(remain), 0);
`endif
        prev_gnt = gnt;
        set_dly(0, 5);
        set_dly(3, 0);
        req = 4'b1001;
        #1;
        rst = 1'b1;
        push(0, 5, 1);
        push(3, 0, 1);
        tick();
        check("post_rst_gnt", 32'(gnt), 4'b0001);
        wait_done(12);
        req = 4'b1000;
        wait_done(10);
        req = '0;
        tick();

        // maximum delay, counter must not wrap
        set_dly(1, 255);
        req = 4'b0010;
        push(1, 255, 1);
        tick();
        check("max_gnt", 32'(gnt), 4'b0010);
        for (int i = 0; i < 256; i++) begin
`ifdef DELAY_ARBITER_REMAIN_OUT_EN
            check("max_remain", 32'(remain), 32'(255 - i));
`endif
            if (i == 128) check("max_no_early_done", 32'(done), 0);
            tick();
        end
        check("max_done", 32'(done), 4'b0010);
`ifdef DELAY_ARBITER_REMAIN_OUT_EN
        check("max_remain_done", 32'(remain), 0);
`endif
        req = '0;
        tick();
        check("max_idle", 32'(busy), 0);

        check("gnt_queue_empty", 32'(exp_gnt.size()), 0);
        check("done_queue_empty", 32'(exp_done.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
